modport_blk: RTL and testbench

//  Single-bank command sequencer between the request queue (REQ_IF DST side) and the

---
 rtl/modport_blk.sv | 153 +++++++++++++++
 tb/tb_modport_blk.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/modport_blk.sv
// Single-bank ACT/RD/WR/PRE sequencer, open-page; combinational requests, grants same cycle, fields hold until granted.
// Optional idle auto-close of the open row under `MODPORT_ROW_TIMEOUT_EN (uses row_open_cnt).
module modport_blk #(
  parameter int BANK_ID   = 0,
  parameter int BA_WIDTH  = 2,
  parameter int RA_WIDTH  = 16,
  parameter int CA_WIDTH  = 10,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 8,
  parameter int T_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [T_WIDTH-1:0]   t_rc_m1,
  input  logic [T_WIDTH-1:0]   t_rcd_m1,
  input  logic [T_WIDTH-1:0]   t_rp_m1,
  input  logic [T_WIDTH-1:0]   t_ras_m1,
  input  logic [T_WIDTH-1:0]   t_rtp_m1,
  input  logic [T_WIDTH-1:0]   t_wtp_m1,
  input  logic [T_WIDTH-1:0]   row_open_cnt,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ID_WIDTH-1:0]  req_id,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic [RA_WIDTH-1:0]  req_ra,
  input  logic [CA_WIDTH-1:0]  req_ca,
  output logic                 act_req,
  output logic                 rd_req,
  output logic                 wr_req,
  output logic                 pre_req,
  input  logic                 act_gnt,
  input  logic                 rd_gnt,
  input  logic                 wr_gnt,
  input  logic                 pre_gnt,
  output logic [BA_WIDTH-1:0]  sched_ba,
  output logic [RA_WIDTH-1:0]  sched_ra,
  output logic [CA_WIDTH-1:0]  sched_ca,
  output logic [ID_WIDTH-1:0]  sched_id,
  output logic [LEN_WIDTH-1:0] sched_len
);

  typedef enum logic {S_CLOSED = 1'b0, S_OPEN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [RA_WIDTH-1:0] r_open_row;
  logic [T_WIDTH-1:0]  r_trc, r_trcd, r_trp, r_tras, r_trtp, r_twtp;
  logic                w_act_fire, w_rd_fire, w_wr_fire, w_pre_fire;
  logic                w_hit, w_miss, w_pre_ok, w_timeout;

  function automatic logic [T_WIDTH-1:0] f_dec(input logic [T_WIDTH-1:0] v);
    return (v == '0) ? v : v - T_WIDTH'(1);
  endfunction

  assign w_hit      = req_valid & (req_ra == r_open_row);
  assign w_miss     = req_valid & (req_ra != r_open_row);
  assign w_pre_ok   = (r_tras == '0) & (r_trtp == '0) & (r_twtp == '0);
  assign w_act_fire = act_req & act_gnt;
  assign w_rd_fire  = rd_req & rd_gnt;
  assign w_wr_fire  = wr_req & wr_gnt;
  assign w_pre_fire = pre_req & pre_gnt;
  assign req_ready  = w_rd_fire | w_wr_fire;
  assign sched_ba   = BA_WIDTH'(BANK_ID);

`ifdef MODPORT_ROW_TIMEOUT_EN
  logic [T_WIDTH-1:0] r_idle;
  logic [T_WIDTH:0]   w_idle_nxt;

  // The current idle cycle counts, so the close fires on the Nth idle cycle.
  assign w_idle_nxt = {1'b0, r_idle} + (T_WIDTH+1)'(1);
  assign w_timeout  = (r_state == S_OPEN) & ~req_valid & (w_idle_nxt >= {1'b0, row_open_cnt});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if ((r_state != S_OPEN) || req_valid) begin
      r_idle <= '0;
    end else if (r_idle != '1) begin
      r_idle <= r_idle + T_WIDTH'(1);
    end
  end
`else
  logic w_unused_row_open_cnt;
  assign w_unused_row_open_cnt = ^row_open_cnt;
  assign w_timeout = 1'b0;
`endif

  // Outputs are gated by rst_n so they drop in the same cycle reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    act_req     = 1'b0;
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    pre_req     = 1'b0;
    sched_ra    = '0;
    sched_ca    = '0;
    sched_id    = '0;
    sched_len   = '0;
    if (rst_n) begin
      case (r_state)
        S_CLOSED: begin
          act_req  = req_valid & (r_trc == '0) & (r_trp == '0);
          sched_ra = req_ra;
          if (act_req && act_gnt) w_state_nxt = S_OPEN;
        end
        default: begin
          sched_ra = r_open_row;
          if (w_hit) begin
            if (r_trcd == '0) begin
              rd_req    = ~req_wr;
              wr_req    = req_wr;
              sched_ca  = req_ca;
              sched_id  = req_id;
              sched_len = req_len;
            end
          end else if ((w_miss || w_timeout) && w_pre_ok) begin
            pre_req = 1'b1;
            if (pre_gnt) w_state_nxt = S_CLOSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLOSED;
      r_open_row <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_act_fire) r_open_row <= req_ra;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trc  <= '0;
      r_trcd <= '0;
      r_tras <= '0;
      r_trp  <= '0;
      r_trtp <= '0;
      r_twtp <= '0;
    end else begin
      r_trc  <= w_act_fire ? t_rc_m1  : f_dec(r_trc);
      r_trcd <= w_act_fire ? t_rcd_m1 : f_dec(r_trcd);
      r_tras <= w_act_fire ? t_ras_m1 : f_dec(r_tras);
      r_trtp <= w_rd_fire  ? t_rtp_m1 : f_dec(r_trtp);
      r_twtp <= w_wr_fire  ? t_wtp_m1 : f_dec(r_twtp);
      r_trp  <= w_pre_fire ? t_rp_m1  : f_dec(r_trp);
    end
  end

endmodule

// File: tb/tb_modport_blk.sv
// Directed bench for modport_blk: timing windows, hits/misses, stalls, reset and idle close.
module tb_modport_blk;

  localparam int SEL_PRE = 0, SEL_WR = 1, SEL_RD = 2, SEL_ACT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, row_open_cnt;
  logic        req_valid, req_ready, req_wr;
  logic [3:0]  req_id;
  logic [7:0]  req_len;
  logic [15:0] req_ra;
  logic [9:0]  req_ca;
  logic        act_req, rd_req, wr_req, pre_req;
  logic        act_gnt, rd_gnt, wr_gnt, pre_gnt;
  logic [1:0]  sched_ba;
  logic [15:0] sched_ra;
  logic [9:0]  sched_ca;
  logic [3:0]  sched_id;
  logic [7:0]  sched_len;
  logic [3:0]  w_reqs;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  always #5 clk = ~clk;
  assign w_reqs = {act_req, rd_req, wr_req, pre_req};

  modport_blk dut (
    .clk(clk), .rst_n(rst_n),
    .t_rc_m1(t_rc_m1), .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1),
    .t_ras_m1(t_ras_m1), .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
    .row_open_cnt(row_open_cnt),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_id(req_id), .req_len(req_len), .req_ra(req_ra), .req_ca(req_ca),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt),
    .sched_ba(sched_ba), .sched_ra(sched_ra), .sched_ca(sched_ca),
    .sched_id(sched_id), .sched_len(sched_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles waited until the selected request rises (max on expiry).
  task automatic wait_bit(input int sel, input int max, output int cnt);
    #1;
    cnt = 0;
    while (w_reqs[sel] !== 1'b1 && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  // Grants the selected request in the current cycle and checks req_ready.
  task automatic grant(input int sel, input string tag);
    act_gnt = (sel == SEL_ACT);
    rd_gnt  = (sel == SEL_RD);
    wr_gnt  = (sel == SEL_WR);
    pre_gnt = (sel == SEL_PRE);
    #1;
    chk({tag, "_req"}, 32'(w_reqs[sel]), 32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'((sel == SEL_RD) || (sel == SEL_WR)));
    tick();
    {act_gnt, rd_gnt, wr_gnt, pre_gnt} = 4'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, row_open_cnt} = '0;
    {req_valid, req_wr, req_id, req_len, req_ra, req_ca} = '0;
    {act_gnt, rd_gnt, wr_gnt, pre_gnt} = 4'b0;
    #12;
    chk("rst_reqs", 32'(w_reqs), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ra", 32'(sched_ra), 32'h0);
    chk("rst_ba", 32'(sched_ba), 32'h0);
    req_valid = 1'b1; req_ra = 16'd5;
    #1;
    chk("rst_valid_reqs", 32'(w_reqs), 32'h0);
    tick();
    rst_n = 1'b1;

    // Read with tRCD_m1=3: ACT at cycle 0, RD at cycle 4.
    t_rcd_m1 = 8'd3; req_id = 4'd3; req_len = 8'd7; req_ca = 10'd0;
    wait_bit(SEL_ACT, 5, n);
    chk("rd_act_wait", n, 0);
    chk("rd_act_ra", 32'(sched_ra), 32'd5);
    grant(SEL_ACT, "rd_act");
    wait_bit(SEL_RD, 10, n);
    chk("rd_trcd", n, 3);
    chk("rd_ca", 32'(sched_ca), 32'd0);
    chk("rd_id", 32'(sched_id), 32'd3);
    chk("rd_len", 32'(sched_len), 32'd7);
    chk("rd_ra", 32'(sched_ra), 32'd5);
    grant(SEL_RD, "rd_gnt");

    // Second hit to row 5: no further ACT.
    req_ca = 10'd8; req_id = 4'd9;
    #1;
    chk("hit2_reqs", 32'(w_reqs), 32'b0100);
    chk("hit2_ca", 32'(sched_ca), 32'd8);
    chk("hit2_id", 32'(sched_id), 32'd9);
    grant(SEL_RD, "hit2_gnt");

    // Miss to row 9, then tRP window before the ACT.
    t_rp_m1 = 8'd2; t_ras_m1 = 8'd10; req_ra = 16'd9;
    wait_bit(SEL_PRE, 5, n);
    chk("miss_pre_wait", n, 0);
    grant(SEL_PRE, "miss_pre");
    wait_bit(SEL_ACT, 10, n);
    chk("miss_trp", n, 2);
    chk("miss_act_ra", 32'(sched_ra), 32'd9);
    grant(SEL_ACT, "miss_act");
    req_ra = 16'd5;
    wait_bit(SEL_PRE, 20, n);
    chk("miss_tras", n, 10);
    grant(SEL_PRE, "tras_pre");

    // Write then miss: tWTP_m1=6 holds PRE off 7 cycles.
    t_ras_m1 = 8'd0; t_wtp_m1 = 8'd6; req_wr = 1'b1;
    wait_bit(SEL_ACT, 10, n);
    chk("wr_trp", n, 2);
    grant(SEL_ACT, "wr_act");
    wait_bit(SEL_WR, 10, n);
    chk("wr_trcd", n, 3);
    grant(SEL_WR, "wr_gnt");
    req_wr = 1'b0; req_ra = 16'd9;
    wait_bit(SEL_PRE, 20, n);
    chk("wr_twtp", n, 6);
    grant(SEL_PRE, "wr_pre");

    // Grants withheld: requests and fields hold, no ready.
    req_ca = 10'h155; req_id = 4'd6; req_len = 8'hA5;
    wait_bit(SEL_ACT, 10, n);
    chk("stall_act_wait", n, 2);
    for (int i = 0; i < 20; i++) begin
      chk("stall_act_reqs", 32'(w_reqs), 32'b1000);
      chk("stall_act_ra", 32'(sched_ra), 32'd9);
      chk("stall_act_ready", 32'(req_ready), 32'd0);
      tick();
    end
    grant(SEL_ACT, "stall_act");
    wait_bit(SEL_RD, 10, n);
    chk("stall_trcd", n, 3);
    for (int i = 0; i < 20; i++) begin
      chk("stall_rd_reqs", 32'(w_reqs), 32'b0100);
      chk("stall_rd_fld", {10'(sched_ca), 4'(sched_id), 8'(sched_len)}, {10'h155, 4'd6, 8'hA5});
      chk("stall_rd_ready", 32'(req_ready), 32'd0);
      tick();
    end
    grant(SEL_RD, "stall_rd");

    // Reset while OPEN: outputs drop at once, ACT comes first afterwards.
    #1;
    chk("pre_rst_reqs", 32'(w_reqs), 32'b0100);
    rst_n = 1'b0;
    #1;
    chk("midrst_reqs", 32'(w_reqs), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    chk("midrst_ra", 32'(sched_ra), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("postrst_reqs", 32'(w_reqs), 32'b1000);
    chk("postrst_ra", 32'(sched_ra), 32'd9);
    grant(SEL_ACT, "postrst_act");

    // Idle close after 4 idle cycles (only with the timeout build).
    row_open_cnt = 8'd4;
    wait_bit(SEL_RD, 10, n);
    chk("to_trcd", n, 3);
    grant(SEL_RD, "to_rd");
    req_valid = 1'b0;
    wait_bit(SEL_PRE, 30, n);
`ifdef MODPORT_ROW_TIMEOUT_EN
    chk("to_pre_wait", n, 3);
    grant(SEL_PRE, "to_pre");
`else
    chk("no_to_pre_wait", n, 30);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
